// File: rtl/rca_pkg.sv
// Shared types for the pipelined ripple-carry adder/subtractor.
package rca_pkg;

  // Operation selector carried with every operand beat.
  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

endpackage : rca_pkg

// File: rtl/rca_slice.sv
// Combinational W-bit ripple-carry slice. Also exposes the carry into the
// slice's top bit so the last slice can form the signed overflow flag.
module rca_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_sum,
  output logic         o_cout,
  output logic         o_c_msb
);

  logic [W:0] w_c;

  // Ripple the carry LSB to MSB, one full adder per bit.
  always_comb begin
    w_c    = '0;
    o_sum  = '0;
    w_c[0] = i_cin;
    for (int i = 0; i < W; i++) begin
      o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
      w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end
  end

  assign o_cout  = w_c[W];
  assign o_c_msb = w_c[W-1];

endmodule : rca_slice

// File: rtl/rca_pipe_addsub.sv
// Pipelined ripple-carry adder/subtractor with a valid/ready stream interface.
// The N-bit word is processed W = N/STAGES bits per stage, LSB slice first;
// each stage registers its partial sum and the carry into the next slice.
// A single global advance signal stalls the whole pipeline on backpressure.
module rca_pipe_addsub #(
  parameter int N      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic         in_cin,
  input  logic         in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_sum,
  output logic         out_cout,
  output logic         out_ovf
);
  import rca_pkg::*;

  localparam int W = N / STAGES;

  if (STAGES < 1 || (N % STAGES) != 0) begin : g_bad_cfg
    $fatal(1, "rca_pipe_addsub: N must be a multiple of STAGES");
  end

  // One pipeline register: partial sum for finished slices, the still-pending
  // operand bits (b already inverted for subtract) and the carry into the next
  // slice. After the last slice, carry is the carry-out of the full word.
  typedef struct packed {
    logic         vld;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] sum;
    logic         carry;
    logic         ovf;
  } stage_t;

  mode_e  w_mode;
  logic   w_adv;
  stage_t w_in;
  stage_t w_q [STAGES];

  assign w_mode = mode_e'(in_mode);

  // Subtract is a + ~b + 1; the incoming borrow flips the injected carry.
  always_comb begin
    w_in       = '0;
    w_in.vld   = in_valid;
    w_in.a     = in_a;
    w_in.b     = (w_mode == MODE_SUB) ? ~in_b : in_b;
    w_in.carry = in_cin ^ (w_mode == MODE_SUB);
  end

  // Whole pipe moves together whenever the output slot is free or being taken.
  assign w_adv    = out_ready | ~w_q[STAGES-1].vld;
  assign in_ready = w_adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t         w_src;
    stage_t         w_d;
    stage_t         r_q;
    logic [W-1:0]   w_sum;
    logic           w_cout;
    logic           w_cmsb;

    if (k == 0) begin : g_first
      assign w_src = w_in;
    end else begin : g_next
      assign w_src = w_q[k-1];
    end

    rca_slice #(.W(W)) u_slice (
      .i_a     (w_src.a[k*W +: W]),
      .i_b     (w_src.b[k*W +: W]),
      .i_cin   (w_src.carry),
      .o_sum   (w_sum),
      .o_cout  (w_cout),
      .o_c_msb (w_cmsb)
    );

    // Merge this slice's sum bits and outgoing carry into the beat; the
    // overflow term is only meaningful once the MSB slice has run.
    always_comb begin
      w_d                 = w_src;
      w_d.sum[k*W +: W]   = w_sum;
      w_d.carry           = w_cout;
      w_d.ovf             = w_cmsb ^ w_cout;
    end

    // Stage k register: loads on advance, cleared on reset so no beat survives.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_q <= '0;
      end else if (w_adv) begin
        r_q <= w_d;
      end
    end

    assign w_q[k] = r_q;
  end

  assign out_valid = w_q[STAGES-1].vld;
  assign out_sum   = w_q[STAGES-1].sum;
  assign out_cout  = w_q[STAGES-1].carry;
  assign out_ovf   = w_q[STAGES-1].ovf;

endmodule : rca_pipe_addsub

// File: tb/tb_rca_pipe_addsub.sv
// Bench for rca_pipe_addsub: N=8/STAGES=2 directed and stall/reset sequences,
// plus exhaustive streamed N=4 runs with STAGES 1, 2 and 4.
module tb_rca_pipe_addsub;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0;
  logic go4 = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic. Returns {ovf, cout, sum[7:0]}.
  function automatic logic [9:0] ref_calc(input int n, input int a, input int b,
                                          input int cin, input int md);
    int mask, half, sa, sb, u, s;
    logic c, o;
    mask = (1 << n) - 1;
    half = 1 << (n - 1);
    sa = (a >= half) ? a - (1 << n) : a;
    sb = (b >= half) ? b - (1 << n) : b;
    if (md == 0) begin
      u = a + b + cin;  c = (u > mask);  s = sa + sb + cin;
    end else begin
      u = a - b - cin;  c = (u >= 0);    s = sa - sb - cin;
    end
    o = (s >= half) || (s < -half);
    return {o, c, 8'(u & mask)};
  endfunction

  // ---------------- main DUT, N=8 STAGES=2 ----------------
  logic       m_v, m_rdy, m_cin, m_mode, m_ov, m_ordy, m_co, m_of;
  logic [7:0] m_a, m_b, m_sum;

  rca_pipe_addsub #(.N(8), .STAGES(2)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(m_v), .in_ready(m_rdy), .in_a(m_a), .in_b(m_b),
    .in_cin(m_cin), .in_mode(m_mode),
    .out_valid(m_ov), .out_ready(m_ordy), .out_sum(m_sum),
    .out_cout(m_co), .out_ovf(m_of)
  );

  logic [9:0] got8[$];
  logic [9:0] exp8[$];

  // Output monitor: records every transferred result beat.
  always begin
    @(negedge clk);
    #2;
    if (!rst && m_ov && m_ordy) got8.push_back({m_of, m_co, m_sum});
  end

  typedef struct {
    logic [7:0] a, b;
    logic       cin, md;
    logic [7:0] sum;
    logic       cout, ovf;
  } vec_t;

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic md);
    int t = 0;
    m_a = a; m_b = b; m_cin = cin; m_mode = md; m_v = 1'b1;
    #1;
    while (!m_rdy && t < 50) begin
      @(negedge clk); #1; t++;
    end
    chk("send_accept", m_rdy, 1);
    exp8.push_back(ref_calc(8, a, b, cin, md));
    @(negedge clk);
  endtask

  task automatic drain();
    for (int c = 0; c < 60 && got8.size() < exp8.size(); c++) begin
      @(negedge clk); #3;
    end
    @(negedge clk);
    chk("drain_count", got8.size(), exp8.size());
  endtask

  task automatic lat_check(input string nm, input logic [7:0] a, input logic [7:0] b,
                           input logic cin, input logic md);
    int lat;
    m_a = a; m_b = b; m_cin = cin; m_mode = md; m_v = 1'b1;
    #1;
    chk({nm, "_in_ready"}, m_rdy, 1);
    @(negedge clk);
    m_v = 1'b0;
    lat = 1;
    #1;
    while (!m_ov && lat < 20) begin
      @(negedge clk); #1; lat++;
    end
    chk({nm, "_latency"}, lat, 2);
    chk({nm, "_result"}, {m_of, m_co, m_sum}, ref_calc(8, a, b, cin, md));
    @(negedge clk);
    got8.delete();
    exp8.delete();
  endtask

  initial begin
    vec_t tbl[12];
    logic stale;
    logic [10:0] snap;

    tbl[0]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[1]  = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    tbl[2]  = '{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    tbl[3]  = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[4]  = '{8'h10, 8'h20, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0};
    tbl[5]  = '{8'h05, 8'h03, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
    tbl[6]  = '{8'h03, 8'h05, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
    tbl[7]  = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[8]  = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
    tbl[9]  = '{8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
    tbl[10] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
    tbl[11] = '{8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};

    rst = 1'b1;
    m_v = 1'b0; m_a = '0; m_b = '0; m_cin = 1'b0; m_mode = 1'b0; m_ordy = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", m_ov, 0);
    chk("rst_out_sum", m_sum, 0);
    chk("rst_out_cout", m_co, 0);
    chk("rst_out_ovf", m_of, 0);
    chk("rst_in_ready", m_rdy, 1);
    rst = 1'b0;
    @(negedge clk);

    // Single ADD with carry out, latency measured
    lat_check("t1_add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0);

    // Table vectors streamed back to back
    for (int i = 0; i < 12; i++) send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].md);
    m_v = 1'b0;
    drain();
    for (int i = 0; i < 12; i++)
      if (i < got8.size())
        chk($sformatf("vec%0d", i), got8[i], {tbl[i].ovf, tbl[i].cout, tbl[i].sum});
    got8.delete(); exp8.delete();

    // Five random beats with a 3-cycle out_ready stall in the middle
    fork
      begin
        for (int i = 0; i < 5; i++)
          send(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      end
      begin
        repeat (3) @(negedge clk);
        m_ordy = 1'b0;
        #2;
        snap = {m_ov, m_of, m_co, m_sum};
        chk("stall_out_valid", m_ov, 1);
        chk("stall_in_ready", m_rdy, 0);
        repeat (2) begin
          @(negedge clk); #2;
          chk("stall_hold", {m_ov, m_of, m_co, m_sum}, snap);
          chk("stall_in_ready", m_rdy, 0);
        end
        @(negedge clk);
        m_ordy = 1'b1;
      end
    join
    m_v = 1'b0;
    drain();
    chk("stream_count", got8.size(), 5);
    for (int i = 0; i < exp8.size(); i++)
      if (i < got8.size()) chk($sformatf("stream%0d", i), got8[i], exp8[i]);
    got8.delete(); exp8.delete();

    // Reset with two beats in flight
    send(8'h11, 8'h22, 1'b0, 1'b0);
    send(8'h33, 8'h44, 1'b1, 1'b1);
    m_v = 1'b0;
    #1;
    chk("pre_rst_out_valid", m_ov, 1);
    rst = 1'b1;
    #1;
    chk("rst_async_out_valid", m_ov, 0);
    @(negedge clk);
    rst = 1'b0;
    stale = 1'b0;
    repeat (6) begin
      @(negedge clk); #1;
      if (m_ov) stale = 1'b1;
    end
    chk("no_stale_after_rst", stale, 0);
    @(negedge clk);
    got8.delete(); exp8.delete();
    lat_check("t5_after_rst", 8'h5A, 8'h3C, 1'b0, 1'b1);

    // Exhaustive N=4 runs
    go4 = 1'b1;
    for (int c = 0; c < 60000 && n_done < 3; c++) @(negedge clk);
    chk("n4_runs_done", n_done, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // ---------------- N=4 DUTs, STAGES = 1, 2, 4 ----------------
  for (genvar g = 0; g < 3; g++) begin : g4
    localparam int S = 1 << g;
    logic       v, rdy, cin, md, ov, ordy, co, of;
    logic [3:0] a, b, s;

    rca_pipe_addsub #(.N(4), .STAGES(S)) u_dut4 (
      .clk(clk), .rst(rst),
      .in_valid(v), .in_ready(rdy), .in_a(a), .in_b(b),
      .in_cin(cin), .in_mode(md),
      .out_valid(ov), .out_ready(ordy), .out_sum(s),
      .out_cout(co), .out_ovf(of)
    );

    initial begin
      logic [9:0] q[$];
      logic [9:0] vec;
      logic       acc;
      int         idx, cyc, lat;

      v = 1'b0; a = '0; b = '0; cin = 1'b0; md = 1'b0; ordy = 1'b1;
      wait (go4);
      @(negedge clk);

      // Unstalled latency probe
      a = 4'd3; b = 4'd4; cin = 1'b0; md = 1'b0; v = 1'b1;
      #1;
      chk($sformatf("s%0d_probe_in_ready", S), rdy, 1);
      @(negedge clk);
      v = 1'b0;
      lat = 1;
      #1;
      while (!ov && lat < 20) begin
        @(negedge clk); #1; lat++;
      end
      chk($sformatf("s%0d_latency", S), lat, S);
      chk($sformatf("s%0d_probe_result", S), {of, co, 4'b0, s}, ref_calc(4, 3, 4, 0, 0));
      @(negedge clk);

      // All (mode, cin, b, a) vectors with random valid and ready
      acc = 1'b0; idx = 0; cyc = 0;
      while ((idx < 1024 || q.size() != 0 || acc) && cyc < 20000) begin
        @(negedge clk);
        cyc++;
        if (acc) begin
          v = 1'b0; acc = 1'b0; idx++;
        end
        ordy = (idx >= 1024) ? 1'b1 : ($urandom_range(0, 3) != 0);
        if (!v && idx < 1024 && $urandom_range(0, 2) != 0) begin
          vec = 10'(idx);
          {md, cin, b, a} = vec;
          v = 1'b1;
        end
        #2;
        if (ov && ordy) begin
          chk($sformatf("s%0d_unexpected_out", S), (q.size() > 0), 1);
          if (q.size() > 0)
            chk($sformatf("s%0d_vec", S), {of, co, 4'b0, s}, q.pop_front());
        end
        if (v && rdy) begin
          q.push_back(ref_calc(4, a, b, cin, md));
          acc = 1'b1;
        end
      end
      v = 1'b0;
      chk($sformatf("s%0d_all_sent", S), idx, 1024);
      chk($sformatf("s%0d_all_received", S), q.size(), 0);
      n_done++;
    end
  end

endmodule : tb_rca_pipe_addsub
